// File: rtl/fetch_predict.sv
// Fetch front end: PC, BLT next-PC selection, fetch queue, mispredict redirect.
// Define BRANCH_PREDICT_EN to enable BLT-driven prediction and BLT updates.
module fetch_predict #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [ADDR_WIDTH-1:0]  blt_read_key,
    input  logic [ADDR_WIDTH-1:0]  blt_read_val,
    input  logic                   blt_read_valid,
    output logic                   blt_write,
    output logic [ADDR_WIDTH-1:0]  blt_write_key,
    output logic [ADDR_WIDTH-1:0]  blt_write_val,
    output logic                   blt_hit,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [ADDR_WIDTH-1:0]  dec_pc,
    output logic [INSTR_WIDTH-1:0] dec_instr,
    output logic                   dec_pred_taken,
    output logic [ADDR_WIDTH-1:0]  dec_pred_target,
    input  logic                   ex_branch,
    input  logic [ADDR_WIDTH-1:0]  ex_pc,
    input  logic                   ex_taken,
    input  logic [ADDR_WIDTH-1:0]  ex_target,
    input  logic                   ex_pred_taken,
    input  logic [ADDR_WIDTH-1:0]  ex_pred_target,
    output logic                   flush
);

    localparam int             PTR_W   = $clog2(QUEUE_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(QUEUE_DEPTH);

    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  pc_seq;
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [PTR_W:0]         count;
    logic                   push;
    logic                   pop;
    logic                   mispredict;
    logic                   pred_taken;
    logic [ADDR_WIDTH-1:0]  pred_target;

    logic [ADDR_WIDTH-1:0]  q_pc    [QUEUE_DEPTH];
    logic [INSTR_WIDTH-1:0] q_instr [QUEUE_DEPTH];
    logic                   q_pt    [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]  q_ptgt  [QUEUE_DEPTH];

`ifdef BRANCH_PREDICT_EN
    assign pred_taken  = blt_read_valid;
    assign pred_target = blt_read_val;
`else
    logic unused_blt;
    assign unused_blt  = ^{blt_read_valid, blt_read_val};
    assign pred_taken  = 1'b0;
    assign pred_target = '0;
`endif

    assign imem_addr    = pc;
    assign blt_read_key = pc;
    assign pc_seq       = pc + ADDR_WIDTH'(1);

    assign mispredict = ex_branch &&
                        ((ex_taken != ex_pred_taken) ||
                         (ex_taken && (ex_target != ex_pred_target)));
    assign flush      = mispredict;

    assign dec_valid = (count != '0);
    assign pop       = dec_valid && dec_ready;
    assign push      = !mispredict && ((count < DEPTH_C) || pop);

    assign dec_pc          = q_pc[head];
    assign dec_instr       = q_instr[head];
    assign dec_pred_taken  = q_pt[head];
    assign dec_pred_target = q_ptgt[head];

    // Flush takes priority: the whole queue holds wrong-path work.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (mispredict) begin
            pc    <= ex_taken ? ex_target : ex_pc + ADDR_WIDTH'(1);
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                pc   <= pred_taken ? pred_target : pc_seq;
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]    <= pc;
            q_instr[tail] <= imem_data;
            q_pt[tail]    <= pred_taken;
            q_ptgt[tail]  <= pred_target;
        end
    end

`ifdef BRANCH_PREDICT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blt_write     <= 1'b0;
            blt_write_key <= '0;
            blt_write_val <= '0;
            blt_hit       <= 1'b0;
        end else begin
            blt_write <= ex_branch;
            if (ex_branch) begin
                blt_write_key <= ex_pc;
                blt_write_val <= ex_target;
                blt_hit       <= ex_taken;
            end
        end
    end
`else
    assign blt_write     = 1'b0;
    assign blt_write_key = '0;
    assign blt_write_val = '0;
    assign blt_hit       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_predict.sv
// Directed bench for fetch_predict: vector table plus hand-written
// redirect, prediction and asynchronous reset sequences.
module tb_fetch_predict;

`ifdef BRANCH_PREDICT_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] blt_read_key;
    logic [31:0] blt_read_val;
    logic        blt_read_valid;
    logic        blt_write;
    logic [31:0] blt_write_key;
    logic [31:0] blt_write_val;
    logic        blt_hit;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic        dec_pred_taken;
    logic [31:0] dec_pred_target;
    logic        ex_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        flush;

    logic        pred_on;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    // Instruction memory and one-entry BLT models.
    assign imem_data      = imem_addr ^ 32'hC0DE_0000;
    assign blt_read_valid = pred_on && (blt_read_key == 32'h104);
    assign blt_read_val   = 32'h200;

    fetch_predict #(
        .ADDR_WIDTH (32),
        .INSTR_WIDTH(32),
        .QUEUE_DEPTH(4),
        .RESET_PC   (32'h100)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .blt_read_key   (blt_read_key),
        .blt_read_val   (blt_read_val),
        .blt_read_valid (blt_read_valid),
        .blt_write      (blt_write),
        .blt_write_key  (blt_write_key),
        .blt_write_val  (blt_write_val),
        .blt_hit        (blt_hit),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_instr      (dec_instr),
        .dec_pred_taken (dec_pred_taken),
        .dec_pred_target(dec_pred_target),
        .ex_branch      (ex_branch),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .flush          (flush)
    );

    typedef struct {
        bit          rdy;
        bit          br;
        logic [31:0] epc;
        bit          tk;
        logic [31:0] tgt;
        bit          ptk;
        logic [31:0] ptgt;
        bit          e_v;
        logic [31:0] e_dpc;
        logic [31:0] e_pc;
        bit          e_fl;
        bit          e_bw;
    } vec_t;

    vec_t tv[23];

    function automatic vec_t mk(
        input bit rdy, input bit br, input logic [31:0] epc,
        input bit tk, input logic [31:0] tgt,
        input bit ptk, input logic [31:0] ptgt,
        input bit e_v, input logic [31:0] e_dpc,
        input logic [31:0] e_pc, input bit e_fl, input bit e_bw);
        vec_t v;
        v.rdy = rdy; v.br = br; v.epc = epc; v.tk = tk;
        v.tgt = tgt; v.ptk = ptk; v.ptgt = ptgt; v.e_v = e_v;
        v.e_dpc = e_dpc; v.e_pc = e_pc; v.e_fl = e_fl; v.e_bw = e_bw;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_ex(input bit br, input logic [31:0] epc,
                            input bit tk, input logic [31:0] tgt,
                            input bit ptk, input logic [31:0] ptgt);
        ex_branch      = br;
        ex_pc          = epc;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    initial begin
        //            rdy br epc       tk tgt       ptk ptgt      v  dpc       pc        fl bw
        tv[0]  = mk(H, L, 32'h0,   L, 32'h0,   L, 32'h0,   L, 32'h0,   32'h100, L, L);
        tv[1]  = mk(H, L, 32'h0,   L, 32'h0,   L, 32'h0,   H, 32'h100, 32'h101, L, L);
        tv[2]  = mk(H, L, 32'h0,   L, 32'h0,   L, 32'h0,   H, 32'h101, 32'h102, L, L);
        tv[3]  = mk(L, L, 32'h0,   L, 32'h0,   L, 32'h0,   H, 32'h102, 32'h103, L, L);
        tv[4]  = mk(L, L, 32'h0,   L, 32'h0,   L, 32'h0,   H, 32'h102, 32'h104, L, L);
        tv[5]  = mk(L, L, 32'h0,   L, 32'h0,   L, 32'h0,   H, 32'h102, 32'h105, L, L);
        tv[6]  = mk(L, L, 32'h0,   L, 32'h0,   L, 32'h0,   H, 32'h102, 32'h106, L, L);
        tv[7]  = mk(L, L, 32'h0,   L, 32'h0,   L, 32'h0,   H, 32'h102, 32'h106, L, L);
        tv[8]  = mk(L, L, 32'h0,   L, 32'h0,   L, 32'h0,   H, 32'h102, 32'h106, L, L);
        tv[9]  = mk(H, L, 32'h0,   L, 32'h0,   L, 32'h0,   H, 32'h102, 32'h106, L, L);
        tv[10] = mk(H, L, 32'h0,   L, 32'h0,   L, 32'h0,   H, 32'h103, 32'h107, L, L);
        tv[11] = mk(H, L, 32'h0,   L, 32'h0,   L, 32'h0,   H, 32'h104, 32'h108, L, L);
        tv[12] = mk(H, H, 32'h104, L, 32'h200, H, 32'h200, H, 32'h105, 32'h109, H, L);
        tv[13] = mk(H, L, 32'h0,   L, 32'h0,   L, 32'h0,   L, 32'h0,   32'h105, L, H);
        tv[14] = mk(H, L, 32'h0,   L, 32'h0,   L, 32'h0,   H, 32'h105, 32'h106, L, L);
        tv[15] = mk(H, H, 32'h110, H, 32'h200, H, 32'h200, H, 32'h106, 32'h107, L, L);
        tv[16] = mk(H, H, 32'h120, H, 32'h300, L, 32'h0,   H, 32'h107, 32'h108, H, H);
        tv[17] = mk(H, L, 32'h0,   L, 32'h0,   L, 32'h0,   L, 32'h0,   32'h300, L, H);
        tv[18] = mk(H, L, 32'h0,   L, 32'h0,   L, 32'h0,   H, 32'h300, 32'h301, L, L);
        tv[19] = mk(H, H, 32'h130, H, 32'h400, H, 32'h3FF, H, 32'h301, 32'h302, H, L);
        tv[20] = mk(H, L, 32'h0,   L, 32'h0,   L, 32'h0,   L, 32'h0,   32'h400, L, H);
        tv[21] = mk(H, H, 32'h140, L, 32'h555, L, 32'h777, H, 32'h400, 32'h401, L, L);
        tv[22] = mk(H, L, 32'h0,   L, 32'h0,   L, 32'h0,   H, 32'h401, 32'h402, L, H);

        reset     = 1'b1;
        dec_ready = 1'b1;
        pred_on   = 1'b0;
        drive_ex(L, 32'h0, L, 32'h0, L, 32'h0);
        #1;
        chk("rst_pc", imem_addr, 32'h100);
        chk("rst_key", blt_read_key, 32'h100);
        chk("rst_valid", dec_valid, 32'h0);
        chk("rst_bw", blt_write, 32'h0);
        chk("rst_bkey", blt_write_key, 32'h0);
        chk("rst_bhit", blt_hit, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 23; i++) begin
            dec_ready = tv[i].rdy;
            drive_ex(tv[i].br, tv[i].epc, tv[i].tk, tv[i].tgt,
                     tv[i].ptk, tv[i].ptgt);
            #1;
            chk($sformatf("r%0d_valid", i), dec_valid, 32'(tv[i].e_v));
            chk($sformatf("r%0d_pc", i), imem_addr, tv[i].e_pc);
            chk($sformatf("r%0d_key", i), blt_read_key, tv[i].e_pc);
            chk($sformatf("r%0d_flush", i), flush, 32'(tv[i].e_fl));
            chk($sformatf("r%0d_bw", i), blt_write, 32'(tv[i].e_bw & PRED));
            if (tv[i].e_v) begin
                chk($sformatf("r%0d_dpc", i), dec_pc, tv[i].e_dpc);
                chk($sformatf("r%0d_instr", i), dec_instr,
                    tv[i].e_dpc ^ 32'hC0DE_0000);
                chk($sformatf("r%0d_pt", i), dec_pred_taken, 32'h0);
            end
            @(negedge clk);
        end
        drive_ex(L, 32'h0, L, 32'h0, L, 32'h0);

        // BLT outputs hold the last resolved branch after the pulse.
        #1;
        chk("hold_bw", blt_write, 32'h0);
        chk("hold_key", blt_write_key, PRED ? 32'h140 : 32'h0);
        chk("hold_val", blt_write_val, PRED ? 32'h555 : 32'h0);
        chk("hold_hit", blt_hit, 32'h0);
        @(negedge clk);

        // Correctly predicted taken branch: no flush, one update pulse.
        drive_ex(H, 32'h110, H, 32'h200, H, 32'h200);
        #1;
        chk("ok_flush", flush, 32'h0);
        @(negedge clk);
        drive_ex(L, 32'h0, L, 32'h0, L, 32'h0);
        #1;
        chk("ok_bw", blt_write, 32'(PRED));
        chk("ok_hit", blt_hit, 32'(PRED));
        chk("ok_key", blt_write_key, PRED ? 32'h110 : 32'h0);
        chk("ok_val", blt_write_val, PRED ? 32'h200 : 32'h0);
        @(negedge clk);
        #1;
        chk("ok_bw_end", blt_write, 32'h0);
        chk("ok_hit_hold", blt_hit, 32'(PRED));
        @(negedge clk);

        // Steer pc to 0x104 via a not-taken redirect, then predict 0x200.
        drive_ex(H, 32'h103, L, 32'h0, H, 32'h0);
        #1;
        chk("pr_flush", flush, 32'h1);
        @(negedge clk);
        drive_ex(L, 32'h0, L, 32'h0, L, 32'h0);
        pred_on = 1'b1;
        #1;
        chk("pr_pc", imem_addr, 32'h104);
        chk("pr_valid0", dec_valid, 32'h0);
        @(negedge clk);
        pred_on = 1'b0;
        #1;
        chk("pr_valid1", dec_valid, 32'h1);
        chk("pr_dpc", dec_pc, 32'h104);
        chk("pr_instr", dec_instr, 32'h104 ^ 32'hC0DE_0000);
        chk("pr_pt", dec_pred_taken, 32'(PRED));
        chk("pr_ptgt", dec_pred_target, PRED ? 32'h200 : 32'h0);
        chk("pr_next", imem_addr, PRED ? 32'h200 : 32'h105);

        // Fill the queue, leave a BLT write pending, reset mid-cycle.
        dec_ready = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("full_valid", dec_valid, 32'h1);
        drive_ex(H, 32'h150, L, 32'h0, L, 32'h0);
        chk("full_noflush", flush, 32'h0);
        @(posedge clk);
        #2;
        drive_ex(L, 32'h0, L, 32'h0, L, 32'h0);
        #1;
        chk("pend_bw", blt_write, 32'(PRED));
        reset = 1'b1;
        #1;
        chk("async_valid", dec_valid, 32'h0);
        chk("async_bw", blt_write, 32'h0);
        chk("async_pc", imem_addr, 32'h100);
        chk("async_bkey", blt_write_key, 32'h0);
        @(negedge clk);
        reset     = 1'b0;
        dec_ready = 1'b1;
        #1;
        chk("rel_valid", dec_valid, 32'h0);
        chk("rel_pc", imem_addr, 32'h100);
        @(negedge clk);
        #1;
        chk("rel_dpc0", dec_pc, 32'h100);
        @(negedge clk);
        #1;
        chk("rel_dpc1", dec_pc, 32'h101);
        chk("rel_valid1", dec_valid, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
